music_box_state_play_recording: RTL and testbench
=================================================

Name: music_box_state_play_recording

Overview:
- Playback-side counterpart of the recording user-interface state: reads back the samples stored during a recording, one per 1 kHz tick, and presents them to the audio path.
- Active only while the MusicBoxStateController holds currentState at PLAY_STATE.
- Pulses stateComplete when the stored length has been played, so the controller can return to DoNothing.
- Reads the recording memory through a simple request/valid handshake.

Parameters:
- PLAY_STATE, 5: currentState value that enables this block.
- MAX_SAMPLES, 5000: maximum recording length (5 s at 1 kHz); record_length is clamped to this value.
- ADDR_W, 13: recording memory address width.
- DATA_W, 16: sample width.
- READ_TIMEOUT, 64: clock_50Mhz cycles to wait for mem_rd_valid before declaring a miss.

Ports:
- clock_50Mhz  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- tick_1Khz  in  1  one-cycle enable strobe at 1 kHz, synchronous to clock_50Mhz.
- currentState  in  5  state code from MusicBoxStateController.
- record_length  in  16  number of valid samples written by the recorder; sampled on entry.
- mem_rd_req  out  1  read request, held until accepted.
- mem_rd_addr  out  ADDR_W  read address; stable while mem_rd_req=1.
- mem_rd_valid  in  1  one-cycle strobe; mem_rd_data is valid in the same cycle.
- mem_rd_data  in  DATA_W  sample read from memory.
- sample_out  out  DATA_W  current playback sample, held between updates.
- sample_valid  out  1  one-cycle pulse whenever sample_out updates.
- stateComplete  out  1  one-cycle pulse when playback finishes.
- debugString  out  32  {overrun_cnt[7:0], miss_cnt[7:0], play_addr[15:0]}.

Behaviour:
- Reset (async, reset_n=0): all outputs 0; FSM=IDLE; play_addr=0; len=0; all counters=0.
- States: IDLE, ARM, REQ, WAIT, DONE.
- Any state, currentState!=PLAY_STATE → IDLE next cycle:
  - mem_rd_req, sample_valid, stateComplete forced 0.
  - play_addr=0; sample_out=0; counters retained.
  - An outstanding read is abandoned; a late mem_rd_valid is ignored.
- IDLE:
  - On currentState==PLAY_STATE: len=min(record_length, MAX_SAMPLES); miss_cnt=0; overrun_cnt=0 → ARM.
  - If len==0: → DONE with stateComplete pulsed in the same transition.
- ARM: on tick_1Khz → REQ; mem_rd_req=1, mem_rd_addr=play_addr.
- REQ/WAIT:
  - mem_rd_req stays high until mem_rd_valid (a same-cycle response is legal).
  - On mem_rd_valid: sample_out=mem_rd_data; sample_valid=1 for 1 cycle; mem_rd_req=0; play_addr+1.
  - Timeout: if READ_TIMEOUT cycles elapse from request assertion without valid: sample_out=0; sample_valid pulse; miss_cnt+1 (saturates at 255); play_addr+1; mem_rd_req=0.
  - After either completion: if play_addr==len → DONE with a 1-cycle stateComplete pulse; else → ARM.
- Latency: tick to sample_valid = 1 + memory latency cycles, at most READ_TIMEOUT+1.
- A tick arriving while in REQ/WAIT is dropped and overrun_cnt+1 (saturating); a tick is never queued.
- DONE: outputs idle; sample_out=0; stays in DONE until currentState changes (no re-trigger without leaving and re-entering PLAY_STATE).
- Simultaneous currentState exit and mem_rd_valid: exit wins; no sample_valid.
- Widths: play_addr is 16 bits; mem_rd_addr=play_addr[ADDR_W-1:0].

Optional Feature:
- Macro: PLAYBACK_LOOP_EN
- Defined:
  - At play_addr==len, stateComplete still pulses 1 cycle.
  - play_addr wraps to 0 and FSM → ARM; playback repeats until currentState leaves PLAY_STATE.
  - len==0 behaves as undefined: DONE.
- Undefined: single pass as described above.

Test Plan:
- Reset mid-playback at play_addr=37 → all outputs 0 immediately; play_addr=0 after reset_n rises.
- record_length=4, memory returns 0xA000+addr with 2-cycle latency, 4 ticks → sample_out=0xA000..0xA003; sample_valid ×4; stateComplete 1 cycle after the 4th sample; mem_rd_req never again.
- record_length=0 on entry → stateComplete pulse within 2 cycles; no mem_rd_req.
- Memory never responds, record_length=2 → each tick: sample_out=0 after 64 cycles; miss_cnt=2; stateComplete pulses.
- Tick injected while in WAIT (latency 10) → overrun_cnt=1; address sequence unaffected.
- currentState leaves PLAY_STATE during WAIT, then valid arrives → no sample_valid; FSM=IDLE. With PLAYBACK_LOOP_EN and record_length=3 over 7 ticks → addresses 0,1,2,0,1,2,0; stateComplete ×2.

Source files
------------

// File: rtl/music_box_state_play_recording.sv
// Plays back recorded samples one per 1 kHz tick while currentState == PLAY_STATE.
// Optional macro PLAYBACK_LOOP_EN: wrap to address 0 and repeat instead of stopping.
module music_box_state_play_recording #(
  parameter int PLAY_STATE   = 5,
  parameter int MAX_SAMPLES  = 5000,
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 16,
  parameter int READ_TIMEOUT = 64
) (
  input  logic              clock_50Mhz,
  input  logic              reset_n,
  input  logic              tick_1Khz,
  input  logic [4:0]        currentState,
  input  logic [15:0]       record_length,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              stateComplete,
  output logic [31:0]       debugString
);

  localparam int TW = $clog2(READ_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state;
  logic [15:0]   play_addr;
  logic [15:0]   len;
  logic [7:0]    miss_cnt;
  logic [7:0]    overrun_cnt;
  logic [TW-1:0] timer;

  logic          in_play;
  logic [15:0]   len_in;
  logic          timeout;

  assign in_play     = (currentState == 5'(PLAY_STATE));
  assign len_in      = (record_length > 16'(MAX_SAMPLES)) ? 16'(MAX_SAMPLES) : record_length;
  assign timeout     = (timer == TW'(READ_TIMEOUT - 1));
  assign mem_rd_addr = play_addr[ADDR_W-1:0];
  assign debugString = {overrun_cnt, miss_cnt, play_addr};

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      play_addr     <= 16'd0;
      len           <= 16'd0;
      miss_cnt      <= 8'd0;
      overrun_cnt   <= 8'd0;
      timer         <= '0;
      mem_rd_req    <= 1'b0;
      sample_out    <= '0;
      sample_valid  <= 1'b0;
      stateComplete <= 1'b0;
    end else begin
      sample_valid  <= 1'b0;
      stateComplete <= 1'b0;
      // Leaving the play state abandons any read in flight; counters stay visible.
      if (!in_play) begin
        state      <= S_IDLE;
        mem_rd_req <= 1'b0;
        play_addr  <= 16'd0;
        sample_out <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            len         <= len_in;
            miss_cnt    <= 8'd0;
            overrun_cnt <= 8'd0;
            play_addr   <= 16'd0;
            if (len_in == 16'd0) begin
              state         <= S_DONE;
              stateComplete <= 1'b1;
            end else begin
              state <= S_ARM;
            end
          end
          S_ARM: begin
            // End-of-recording is checked here, one cycle after the last sample lands.
            if (play_addr == len) begin
              stateComplete <= 1'b1;
`ifdef PLAYBACK_LOOP_EN
              play_addr <= 16'd0;
`else
              state <= S_DONE;
`endif
            end else if (tick_1Khz) begin
              state      <= S_REQ;
              mem_rd_req <= 1'b1;
              timer      <= '0;
            end
          end
          S_REQ, S_WAIT: begin
            if (tick_1Khz && overrun_cnt != 8'hFF)
              overrun_cnt <= overrun_cnt + 8'd1;
            if (mem_rd_valid) begin
              sample_out   <= mem_rd_data;
              sample_valid <= 1'b1;
              mem_rd_req   <= 1'b0;
              play_addr    <= play_addr + 16'd1;
              state        <= S_ARM;
            end else if (timeout) begin
              sample_out   <= '0;
              sample_valid <= 1'b1;
              mem_rd_req   <= 1'b0;
              play_addr    <= play_addr + 16'd1;
              if (miss_cnt != 8'hFF)
                miss_cnt <= miss_cnt + 8'd1;
              state <= S_ARM;
            end else begin
              timer <= timer + TW'(1);
              state <= S_WAIT;
            end
          end
          S_DONE: begin
            sample_out <= '0;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_music_box_state_play_recording.sv
// Directed bench for music_box_state_play_recording with a behavioural recording memory.
module tb_music_box_state_play_recording;

  logic        clk;
  logic        reset_n;
  logic        tick_1Khz;
  logic [4:0]  currentState;
  logic [15:0] record_length;
  logic        mem_rd_req;
  logic [12:0] mem_rd_addr;
  logic        mem_rd_valid;
  logic [15:0] mem_rd_data;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        stateComplete;
  logic [31:0] debugString;

  music_box_state_play_recording dut (
    .clock_50Mhz   (clk),
    .reset_n       (reset_n),
    .tick_1Khz     (tick_1Khz),
    .currentState  (currentState),
    .record_length (record_length),
    .mem_rd_req    (mem_rd_req),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_data   (mem_rd_data),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .stateComplete (stateComplete),
    .debugString   (debugString)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model: answers 0xA000+addr a fixed number of cycles after the request rises.
  logic        mem_en = 1'b1;
  int          mem_lat = 2;
  logic        auto_valid = 1'b0;
  logic [15:0] auto_data = 16'h0;
  logic        late_valid = 1'b0;
  int          lat_cnt = 0;
  logic        answered = 1'b0;

  assign mem_rd_valid = auto_valid | late_valid;
  assign mem_rd_data  = late_valid ? 16'h5555 : auto_data;

  always @(negedge clk) begin
    auto_valid = 1'b0;
    if (!mem_rd_req) begin
      lat_cnt  = 0;
      answered = 1'b0;
    end else if (mem_en && !answered) begin
      if (lat_cnt == mem_lat) begin
        auto_valid = 1'b1;
        auto_data  = 16'hA000 + 16'(mem_rd_addr);
        answered   = 1'b1;
      end else begin
        lat_cnt++;
      end
    end
  end

  // Event log sampled away from the active edge.
  int          sv_cnt = 0;
  int          sc_cnt = 0;
  int          rq_cnt = 0;
  logic        req_q  = 1'b0;
  logic [12:0] addr_log [256];

  always @(negedge clk) begin
    if (sample_valid) sv_cnt++;
    if (stateComplete) sc_cnt++;
    if (mem_rd_req && !req_q) begin
      if (rq_cnt < 256) addr_log[rq_cnt] = mem_rd_addr;
      rq_cnt++;
    end
    req_q = mem_rd_req;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse one tick, optionally inject a second tick n cycles later, wait for sample_valid.
  task automatic play_tick(input int inject, output int n);
    n = 0;
    tick_1Khz = 1'b1;
    do begin
      @(negedge clk);
      n++;
      tick_1Khz = (n == inject);
    end while (!sample_valid && n < 200);
    tick_1Khz = 1'b0;
  endtask

  int n;
  int base_sv, base_sc, base_rq;

  initial begin
    reset_n = 1'b0; tick_1Khz = 1'b0; currentState = 5'd0; record_length = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_req",   {31'd0, mem_rd_req}, 32'd0);
    check("rst_addr",  {19'd0, mem_rd_addr}, 32'd0);
    check("rst_smp",   {16'd0, sample_out}, 32'd0);
    check("rst_sv",    {31'd0, sample_valid}, 32'd0);
    check("rst_sc",    {31'd0, stateComplete}, 32'd0);
    check("rst_dbg",   debugString, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Four samples with 2-cycle memory latency
    base_sv = sv_cnt; base_sc = sc_cnt; base_rq = rq_cnt;
    mem_en = 1'b1; mem_lat = 2; record_length = 16'd4; currentState = 5'd5;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      play_tick(0, n);
      check("basic_lat", n, 32'd4);
      check("basic_data", {16'd0, sample_out}, 32'hA000 + i);
      if (i < 3) repeat (2) @(negedge clk);
    end
    @(negedge clk);
    check("basic_sc_pulse", {31'd0, stateComplete}, 32'd1);
    @(negedge clk);
    check("basic_sc_width", {31'd0, stateComplete}, 32'd0);
    repeat (10) @(negedge clk);
    check("basic_sv_cnt", sv_cnt - base_sv, 32'd4);
    check("basic_sc_cnt", sc_cnt - base_sc, 32'd1);
    check("basic_rq_cnt", rq_cnt - base_rq, 32'd4);
    check("basic_dbg", debugString, 32'h0000_0004);
    check("done_smp", {16'd0, sample_out}, 32'd0);
    currentState = 5'd0;
    @(negedge clk);
    check("exit_addr0", debugString, 32'd0);

    // Zero-length recording
    base_rq = rq_cnt; base_sc = sc_cnt;
    record_length = 16'd0; currentState = 5'd5;
    @(negedge clk);
    check("zero_sc", {31'd0, stateComplete}, 32'd1);
    repeat (5) @(negedge clk);
    check("zero_no_req", rq_cnt - base_rq, 32'd0);
    check("zero_sc_once", sc_cnt - base_sc, 32'd1);
    currentState = 5'd0;
    @(negedge clk);

    // One good read, then two reads with no memory answer
    mem_lat = 2; record_length = 16'd3; currentState = 5'd5;
    repeat (2) @(negedge clk);
    play_tick(0, n);
    check("to_first_data", {16'd0, sample_out}, 32'hA000);
    mem_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      repeat (2) @(negedge clk);
      play_tick(0, n);
      check("to_lat", n, 32'd65);
      check("to_data", {16'd0, sample_out}, 32'd0);
    end
    @(negedge clk);
    check("to_sc", {31'd0, stateComplete}, 32'd1);
    check("to_dbg", debugString, 32'h0002_0003);
    currentState = 5'd0; mem_en = 1'b1;
    @(negedge clk);

    // Extra tick while waiting on a slow read
    base_rq = rq_cnt;
    mem_lat = 10; record_length = 16'd3; currentState = 5'd5;
    repeat (2) @(negedge clk);
    play_tick(3, n);
    check("ovr_lat", n, 32'd12);
    check("ovr_data0", {16'd0, sample_out}, 32'hA000);
    repeat (2) @(negedge clk);
    play_tick(0, n);
    check("ovr_data1", {16'd0, sample_out}, 32'hA001);
    repeat (2) @(negedge clk);
    play_tick(0, n);
    check("ovr_data2", {16'd0, sample_out}, 32'hA002);
    @(negedge clk);
    check("ovr_sc", {31'd0, stateComplete}, 32'd1);
    check("ovr_dbg", debugString, 32'h0100_0003);
    check("ovr_rq_cnt", rq_cnt - base_rq, 32'd3);
    currentState = 5'd0;
    @(negedge clk);
    check("exit_keep_cnt", debugString, 32'h0100_0000);

    // Exit during WAIT coinciding with a read response
    mem_en = 1'b0; record_length = 16'd2; currentState = 5'd5;
    repeat (2) @(negedge clk);
    base_sv = sv_cnt;
    tick_1Khz = 1'b1;
    @(negedge clk);
    tick_1Khz = 1'b0;
    repeat (2) @(negedge clk);
    check("exitw_req_hi", {31'd0, mem_rd_req}, 32'd1);
    currentState = 5'd0; late_valid = 1'b1;
    @(negedge clk);
    late_valid = 1'b0;
    check("exitw_req_lo", {31'd0, mem_rd_req}, 32'd0);
    check("exitw_no_sv", {31'd0, sample_valid}, 32'd0);
    late_valid = 1'b1;
    @(negedge clk);
    late_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("exitw_sv_cnt", sv_cnt - base_sv, 32'd0);
    check("exitw_smp", {16'd0, sample_out}, 32'd0);
    check("exitw_dbg", debugString, 32'd0);
    record_length = 16'd0; currentState = 5'd5;
    @(negedge clk);
    check("exitw_idle", {31'd0, stateComplete}, 32'd1);
    currentState = 5'd0; mem_en = 1'b1;
    @(negedge clk);

    // Reset in the middle of playback, with a read outstanding at address 37
    mem_lat = 0; record_length = 16'd100; currentState = 5'd5;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 37; i++) begin
      play_tick(0, n);
      @(negedge clk);
    end
    check("zero_lat", n, 32'd2);
    check("mid_dbg", debugString, 32'h0000_0025);
    mem_lat = 10;
    tick_1Khz = 1'b1;
    @(negedge clk);
    tick_1Khz = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_req", {31'd0, mem_rd_req}, 32'd1);
    check("mid_addr", {19'd0, mem_rd_addr}, 32'd37);
    reset_n = 1'b0;
    #1;
    check("arst_req",  {31'd0, mem_rd_req}, 32'd0);
    check("arst_addr", {19'd0, mem_rd_addr}, 32'd0);
    check("arst_smp",  {16'd0, sample_out}, 32'd0);
    check("arst_dbg",  debugString, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("arst_after", debugString, 32'd0);
    currentState = 5'd0;
    repeat (2) @(negedge clk);

`ifdef PLAYBACK_LOOP_EN
    base_rq = rq_cnt; base_sc = sc_cnt;
    mem_lat = 2; record_length = 16'd3; currentState = 5'd5;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      play_tick(0, n);
      repeat (3) @(negedge clk);
    end
    for (int i = 0; i < 7; i++)
      check("loop_addr", {19'd0, addr_log[base_rq + i]}, i % 3);
    check("loop_sc_cnt", sc_cnt - base_sc, 32'd2);
    currentState = 5'd0;
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
